// File: rtl/wb_copy_pkg.sv
// wb_copy_pkg: shared constants and state encoding for the wb_copy_master
// DMA copy engine.
//   CTI_CLASSIC / CTI_INCR / CTI_EOB : Wishbone B4 cycle type identifiers
//   BTE_LINEAR                       : linear burst type
//   state_e                          : copy engine control states
package wb_copy_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/wb_copy_fifo.sv
// wb_copy_fifo: DEPTH x 32-bit synchronous FIFO with show-ahead output.
// dout is a register that always holds the head word whenever the FIFO is
// not empty, so it can drive a bus output directly.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   flush          : synchronous clear of all contents
//   push, din      : write request and data (ignored when full)
//   pop            : drop the head word (ignored when empty)
//   dout           : head word (registered)
//   empty, full    : occupancy flags
module wb_copy_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] din,
    input  logic        pop,
    output logic [31:0] dout,
    output logic        empty,
    output logic        full
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_nxt_s;
    logic [AW:0]   count_r;
    logic [31:0]   dout_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign empty     = (count_r == {(AW+1){1'b0}});
    assign full      = (count_r == (AW+1)'(DEPTH));
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rd_nxt_s  = rd_ptr_r + AW'(1);
    assign dout      = dout_r;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            dout_r   <= 32'h0000_0000;
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            dout_r   <= 32'h0000_0000;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_nxt_s;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
            // Head moves to the next stored word on pop; a push into an
            // empty (or emptying) FIFO becomes the head immediately.
            if (pop_ok_s) begin
                if (count_r > (AW+1)'(1)) begin
                    dout_r <= mem_r[rd_nxt_s];
                end else if (push_ok_s) begin
                    dout_r <= din;
                end
            end else if (push_ok_s && empty) begin
                dout_r <= din;
            end
        end
    end

endmodule

// File: rtl/wb_copy_master.sv
// wb_copy_master: Wishbone B4 initiator that copies a block of 32-bit words
// from a source to a destination address, chunk by chunk through a local
// buffer (read up to DEPTH words, then write them out, repeat).
// Build option: define WB_COPY_BURST_EN to issue incrementing bursts
// (CTI 3'b010, last beat of each phase 3'b111); otherwise classic cycles.
// Ports:
//   clk, rstn                 : clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready   : command handshake (ready only when idle)
//   i_cmd_src/dst/len         : byte addresses (low 2 bits ignored), words
//   o_busy, o_done, o_err     : status; done is a 1-cycle pulse, err sticky
//   o_wb_*                    : registered Wishbone master outputs
//   i_wb_rdt/ack/err          : Wishbone slave responses
module wb_copy_master
    import wb_copy_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [31:0]      i_cmd_src,
    input  logic [31:0]      i_cmd_dst,
    input  logic [LEN_W-1:0] i_cmd_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [31:0]      o_wb_adr,
    output logic [31:0]      o_wb_dat,
    output logic [3:0]       o_wb_sel,
    output logic             o_wb_we,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    output logic [2:0]       o_wb_cti,
    output logic [1:0]       o_wb_bte,
    input  logic [31:0]      i_wb_rdt,
    input  logic             i_wb_ack,
    input  logic             i_wb_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e           state_r, state_nx;
    logic [31:0]      src_r, src_nx;
    logic [31:0]      dst_r, dst_nx;
    logic [31:0]      adr_r, adr_nx;
    logic [LEN_W-1:0] rem_r, rem_nx;
    logic [CW-1:0]    beat_r, beat_nx;
    logic [CW-1:0]    chunk_r, chunk_nx;
    logic             cyc_r, cyc_nx;
    logic             we_r, we_nx;
    logic             err_r, err_nx;
    logic             done_r, done_nx;
    logic             busy_r, busy_nx;
    logic             ready_r, ready_nx;
    logic [2:0]       cti_r, cti_nx;
    logic [3:0]       sel_r, sel_nx;

    logic             push_s, pop_s, flush_s;
    logic             ack_s, berr_s;
    logic [2:0]       cti_launch_s, cti_next_s;
    logic [31:0]      fifo_dout_s;
    logic             fifo_empty_s, fifo_full_s;
    logic             unused_s;

    // Chunk length is the remaining count capped at the buffer depth.
    function automatic logic [CW-1:0] chunk_of(input logic [LEN_W-1:0] words);
        if (words >= LEN_W'(DEPTH)) begin
            chunk_of = CW'(DEPTH);
        end else begin
            chunk_of = CW'(words);
        end
    endfunction

    // stb mirrors cyc, so responses only count while our cycle is open.
    // An err wins over a simultaneous ack.
    assign ack_s  = i_wb_ack & cyc_r & ~i_wb_err;
    assign berr_s = i_wb_err & cyc_r;

`ifdef WB_COPY_BURST_EN
    assign cti_launch_s = (beat_r == CW'(1)) ? CTI_EOB : CTI_INCR;
    assign cti_next_s   = (beat_r == CW'(2)) ? CTI_EOB : CTI_INCR;
`else
    assign cti_launch_s = CTI_CLASSIC;
    assign cti_next_s   = CTI_CLASSIC;
`endif

    assign unused_s = ^{i_cmd_src[1:0], i_cmd_dst[1:0], fifo_empty_s, fifo_full_s};

    wb_copy_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush_s),
        .push  (push_s),
        .din   (i_wb_rdt),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    // Next-state and next-output logic. Each phase opens its cycle one clock
    // after it is entered, which leaves the mandatory cyc-low gap between
    // the read and write phases.
    always_comb begin
        state_nx = state_r;
        src_nx   = src_r;
        dst_nx   = dst_r;
        adr_nx   = adr_r;
        rem_nx   = rem_r;
        beat_nx  = beat_r;
        chunk_nx = chunk_r;
        cyc_nx   = cyc_r;
        we_nx    = we_r;
        err_nx   = err_r;
        cti_nx   = cti_r;
        done_nx  = 1'b0;
        push_s   = 1'b0;
        pop_s    = 1'b0;
        flush_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (i_cmd_valid && ready_r) begin
                    src_nx = {i_cmd_src[31:2], 2'b00};
                    dst_nx = {i_cmd_dst[31:2], 2'b00};
                    rem_nx = i_cmd_len;
                    err_nx = 1'b0;
                    if (i_cmd_len == {LEN_W{1'b0}}) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_RD;
                        chunk_nx = chunk_of(i_cmd_len);
                        beat_nx  = chunk_of(i_cmd_len);
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end

            ST_RD: begin
                if (!cyc_r) begin
                    cyc_nx = 1'b1;
                    we_nx  = 1'b0;
                    adr_nx = src_r;
                    cti_nx = cti_launch_s;
                end else if (berr_s) begin
                    cyc_nx   = 1'b0;
                    we_nx    = 1'b0;
                    cti_nx   = CTI_CLASSIC;
                    err_nx   = 1'b1;
                    flush_s  = 1'b1;
                    state_nx = ST_DONE;
                end else if (ack_s) begin
                    push_s  = 1'b1;
                    src_nx  = src_r + 32'd4;
                    adr_nx  = src_r + 32'd4;
                    beat_nx = beat_r - CW'(1);
                    cti_nx  = cti_next_s;
                    if (beat_r == CW'(1)) begin
                        cyc_nx   = 1'b0;
                        cti_nx   = CTI_CLASSIC;
                        beat_nx  = chunk_r;
                        state_nx = ST_WR;
                    end else begin
                        state_nx = ST_RD;
                    end
                end else begin
                    state_nx = ST_RD;
                end
            end

            ST_WR: begin
                if (!cyc_r) begin
                    cyc_nx = 1'b1;
                    we_nx  = 1'b1;
                    adr_nx = dst_r;
                    cti_nx = cti_launch_s;
                end else if (berr_s) begin
                    cyc_nx   = 1'b0;
                    we_nx    = 1'b0;
                    cti_nx   = CTI_CLASSIC;
                    err_nx   = 1'b1;
                    flush_s  = 1'b1;
                    state_nx = ST_DONE;
                end else if (ack_s) begin
                    pop_s   = 1'b1;
                    dst_nx  = dst_r + 32'd4;
                    adr_nx  = dst_r + 32'd4;
                    rem_nx  = rem_r - LEN_W'(1);
                    beat_nx = beat_r - CW'(1);
                    cti_nx  = cti_next_s;
                    if (beat_r == CW'(1)) begin
                        cyc_nx = 1'b0;
                        we_nx  = 1'b0;
                        cti_nx = CTI_CLASSIC;
                        if (rem_r == LEN_W'(1)) begin
                            state_nx = ST_DONE;
                        end else begin
                            state_nx = ST_RD;
                            chunk_nx = chunk_of(rem_r - LEN_W'(1));
                            beat_nx  = chunk_of(rem_r - LEN_W'(1));
                        end
                    end else begin
                        state_nx = ST_WR;
                    end
                end else begin
                    state_nx = ST_WR;
                end
            end

            ST_DONE: begin
                done_nx  = 1'b1;
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
                cyc_nx   = 1'b0;
                flush_s  = 1'b1;
            end
        endcase

        sel_nx   = cyc_nx ? 4'hF : 4'h0;
        busy_nx  = (state_nx != ST_IDLE);
        ready_nx = (state_nx == ST_IDLE);
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            src_r   <= 32'h0000_0000;
            dst_r   <= 32'h0000_0000;
            adr_r   <= 32'h0000_0000;
            rem_r   <= {LEN_W{1'b0}};
            beat_r  <= {CW{1'b0}};
            chunk_r <= {CW{1'b0}};
            cyc_r   <= 1'b0;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
            cti_r   <= CTI_CLASSIC;
            sel_r   <= 4'h0;
        end else begin
            state_r <= state_nx;
            src_r   <= src_nx;
            dst_r   <= dst_nx;
            adr_r   <= adr_nx;
            rem_r   <= rem_nx;
            beat_r  <= beat_nx;
            chunk_r <= chunk_nx;
            cyc_r   <= cyc_nx;
            we_r    <= we_nx;
            err_r   <= err_nx;
            done_r  <= done_nx;
            busy_r  <= busy_nx;
            ready_r <= ready_nx;
            cti_r   <= cti_nx;
            sel_r   <= sel_nx;
        end
    end

    assign o_cmd_ready = ready_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_err       = err_r;
    assign o_wb_adr    = adr_r;
    assign o_wb_dat    = fifo_dout_s;
    assign o_wb_sel    = sel_r;
    assign o_wb_we     = we_r;
    assign o_wb_cyc    = cyc_r;
    assign o_wb_stb    = cyc_r;
    assign o_wb_cti    = cti_r;
    assign o_wb_bte    = BTE_LINEAR;

endmodule
